mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the core datapath (PC/instr fetch, Mem_WrAddr/Mem_WrData/ReadData) and a single external memory with a valid/ready request and rvalid response.
- Sequences each access and asserts stall to freeze the core until its access completes.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants while IF is pending, after which IF is forced to win the next arbitration.
- TIMEOUT_CYCLES, 64: cycles spent in REQ+RESP before an access is aborted. Used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held until if_done
- if_addr  input  32  fetch address (PC)
- if_rdata  output  32  fetched instruction; registered; held until the next IF done
- if_done  output  1  one-cycle completion pulse for IF
- ls_req  input  1  load/store request; held until ls_done
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  32  data address (ALU result)
- ls_wdata  input  32  store data
- ls_be  input  4  byte enables
- ls_rdata  output  32  load data; registered; held until the next LS done
- ls_done  output  1  one-cycle completion pulse for LS
- m_valid  output  1  memory request valid
- m_we  output  1  memory write
- m_addr  output  32  memory address
- m_wdata  output  32  memory write data
- m_be  output  4  memory byte enables
- m_ready  input  1  memory accepts the request when m_valid & m_ready
- m_rvalid  input  1  read data valid
- m_rdata  input  32  read data
- stall  output  1  combinational: (if_req & ~if_done) | (ls_req & ~ls_done)
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; all m_* outputs = 0; if_rdata = ls_rdata = 0.
  - if_done = ls_done = 0; starve counter = 0; timeout counter = 0; bus_err = 0.
  - Reset asserted mid-transaction abandons the transaction; no done pulse is produced.
- States: IDLE, REQ, RESP, DONE.
- IDLE, arbitration:
  - ls_req alone: grant LS.
  - if_req alone: grant IF.
  - Both requesting: LS wins unless starve counter = STARVE_LIMIT, in which case IF wins.
  - On grant, latch owner, we, addr, wdata and be (IF: we = 0, be = 4'hF, wdata = 0). Go to REQ.
- Starve counter:
  - Increments on each LS grant made while if_req = 1.
  - Clears on any IF grant.
  - Saturates at STARVE_LIMIT.
- REQ:
  - m_valid = 1 with the latched fields, held stable until m_ready.
  - On m_valid & m_ready: write goes to DONE; read goes to RESP.
  - m_valid drops in the cycle after acceptance.
- RESP:
  - Wait for m_rvalid; capture m_rdata into the owner's rdata register.
  - m_rvalid in the same cycle as acceptance is ignored; RESP always lasts at least 1 cycle.
  - Go to DONE.
- DONE:
  - Pulse the owner's done for exactly 1 cycle, then return to IDLE.
  - No new grant is made in DONE.
- Latency, zero-wait memory (m_ready = 1, m_rvalid in the first RESP cycle):
  - Read: request seen in cycle 0 (IDLE) -> done in cycle 3.
  - Write: done in cycle 2.
- Requester protocol:
  - A requester holds req and its fields stable until its done.
  - If req deasserts after grant, the transaction still completes and done still pulses.
  - Latched fields are used throughout, so input changes after grant have no effect.
- Memory-side rules:
  - m_rvalid outside RESP is ignored.
  - Exactly one outstanding memory transaction at any time.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments in every REQ and RESP cycle.
  - When it reaches TIMEOUT_CYCLES: abort to DONE; a read owner gets rdata = 32'hDEAD_BEEF; bus_err is set (sticky until reset).
  - m_valid drops on abort.
- Undefined:
  - No counter; REQ and RESP wait indefinitely.
  - bus_err is tied to 0 and the port remains present.

Test Plan:
1. IF read, zero-wait: if_req = 1, if_addr = 0x100, m_ready = 1, m_rvalid at the first RESP cycle with m_rdata = 0x00500093 -> m_addr = 0x100 in cycle 1, if_done in cycle 3, if_rdata = 0x00500093, stall low in cycle 4.
2. LS store: ls_req = 1, ls_we = 1, addr 0x2000, wdata 0xCAFEF00D, be = 4'b0011, m_ready delayed 3 cycles -> m_valid with stable fields for 4 cycles, ls_done 1 cycle after acceptance, no RESP state.
3. Simultaneous requests, STARVE_LIMIT = 4, ls_req re-asserted continuously -> 4 LS grants, then IF granted 5th; starve counter cleared after the IF grant.
4. Reset mid-RESP: reset = 0 while waiting for m_rvalid -> all outputs 0 immediately; no done; after release, the next if_req completes normally.
5. MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, load with m_rvalid never asserted -> ls_done 8 cycles after entering REQ, ls_rdata = 0xDEADBEEF, bus_err = 1 and stays 1.
6. Spurious m_rvalid in IDLE with m_rdata = 0x1234 -> if_rdata and ls_rdata unchanged, no done pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one valid/ready memory port.
// Optional access timeout and sticky bus_err: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        stall,
  output logic        bus_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mem_port_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic [SW-1:0] starve_q;
  logic          starved;
  logic          grant_ls;
  logic          grant_if;
  logic          capture;
  logic          abort;
  logic          tmo_hit;

  assign starved = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    state_d  = state_q;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ls_req && !(if_req && starved)) begin
          grant_ls = 1'b1;
          state_d  = REQ;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (m_ready) begin
          state_d = lat_we ? DONE : RESP;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      RESP: begin
        if (m_rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      starve_q  <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_ls) begin
        owner_q   <= 1'b1;
        lat_we    <= ls_we;
        lat_addr  <= ls_addr;
        lat_wdata <= ls_wdata;
        lat_be    <= ls_be;
      end else if (grant_if) begin
        owner_q   <= 1'b0;
        lat_we    <= 1'b0;
        lat_addr  <= if_addr;
        lat_wdata <= '0;
        lat_be    <= 4'hF;
      end
      if (grant_if) begin
        starve_q <= '0;
      end else if (grant_ls && if_req && !starved) begin
        starve_q <= starve_q + 1'b1;
      end
      // an aborted read still hands its owner a recognisable word
      if (capture || (abort && !lat_we)) begin
        if (owner_q) begin
          ls_rdata <= capture ? m_rdata : 32'hDEAD_BEEF;
        end else begin
          if_rdata <= capture ? m_rdata : 32'hDEAD_BEEF;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          bus_err_q;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (grant_ls || grant_if) begin
        tmo_q <= '0;
      end else if (state_q == REQ || state_q == RESP) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (abort) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign m_valid = (state_q == REQ);
  assign m_we    = m_valid & lat_we;
  assign m_addr  = {32{m_valid}} & lat_addr;
  assign m_wdata = {32{m_valid}} & lat_wdata;
  assign m_be    = {4{m_valid}} & lat_be;

  assign if_done = (state_q == DONE) & ~owner_q;
  assign ls_done = (state_q == DONE) & owner_q;
  assign stall   = (if_req & ~if_done) | (ls_req & ~ls_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks for mem_port_arbiter.
// Directed timeout steps run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        stall;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .STARVE_LIMIT  (LIMIT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_done (if_done),
    .ls_req  (ls_req),
    .ls_we   (ls_we),
    .ls_addr (ls_addr),
    .ls_wdata(ls_wdata),
    .ls_be   (ls_be),
    .ls_rdata(ls_rdata),
    .ls_done (ls_done),
    .m_valid (m_valid),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_ready (m_ready),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .stall   (stall),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          ls_cnt;
    bit          got;
    bit          out_valid, out_ls, out_we, data_ok;
    bit          resp_wait, acc_prev, m_valid_prev, if_prev, ls_prev;
    bit          is_ls;
    int          wait_cnt, rv_wait, run;
    logic [31:0] exp_data;
    logic [68:0] saved;
    logic [68:0] want;

    reset    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    ls_be    = '0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    repeat (2) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;
    tick();

    // IF read with zero-wait memory
    if_req  = 1'b1;
    if_addr = 32'h100;
    m_ready = 1'b1;
    tick();
    chk("t1_valid", m_valid, 1);
    chk("t1_addr", m_addr, 32'h100);
    chk("t1_we", m_we, 0);
    chk("t1_be", m_be, 4'hF);
    tick();
    chk("t1_no_early_done", if_done, 0);
    m_rvalid = 1'b1;
    m_rdata  = 32'h0050_0093;
    tick();
    chk("t1_done", if_done, 1);
    chk("t1_rdata", if_rdata, 32'h0050_0093);
    chk("t1_valid_low", m_valid, 0);
    if_req   = 1'b0;
    m_rvalid = 1'b0;
    tick();
    chk("t1_done_pulse", if_done, 0);
    chk("t1_stall_low", stall, 0);

    // spurious rvalid while idle
    m_rvalid = 1'b1;
    m_rdata  = 32'h1234;
    tick();
    tick();
    chk("t6_if_done", if_done, 0);
    chk("t6_ls_done", ls_done, 0);
    chk("t6_if_rdata", if_rdata, 32'h0050_0093);
    chk("t6_ls_rdata", ls_rdata, 0);
    m_rvalid = 1'b0;

    // store with delayed m_ready; address changes after grant
    m_ready  = 1'b0;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h2000;
    ls_wdata = 32'hCAFE_F00D;
    ls_be    = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_valid%0d", i), m_valid, 1);
      chk($sformatf("t2_fields%0d", i), {m_we, m_addr, m_wdata, m_be},
          {1'b1, 32'h2000, 32'hCAFE_F00D, 4'b0011});
      if (i == 1) chk("t2_stall", stall, 1);
      if (i == 0) ls_addr = 32'hFFFF_0000;
      if (i == 3) m_ready = 1'b1;
    end
    tick();
    chk("t2_done", ls_done, 1);
    chk("t2_valid_low", m_valid, 0);
    ls_req = 1'b0;
    tick();
    chk("t2_done_pulse", ls_done, 0);

    // starvation: LS hogs the port, IF wins after LIMIT grants
    m_ready  = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'hABCD_0001;
    ls_we    = 1'b1;
    ls_addr  = 32'h3000;
    ls_wdata = 32'h5555_AAAA;
    ls_be    = 4'hF;
    if_addr  = 32'h200;
    if_req   = 1'b1;
    ls_req   = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ls_cnt = 0;
      got    = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        tick();
        if (ls_done) ls_cnt++;
        if (if_done) got = 1'b1;
      end
      chk($sformatf("t3_if_served%0d", r), got, 1);
      chk($sformatf("t3_ls_before_if%0d", r), ls_cnt, LIMIT);
      chk($sformatf("t3_if_rdata%0d", r), if_rdata, 32'hABCD_0001);
    end
    if_req   = 1'b0;
    ls_req   = 1'b0;
    m_rvalid = 1'b0;
    repeat (2) tick();

    // reset while waiting in RESP
    if_req  = 1'b1;
    if_addr = 32'h300;
    tick();
    chk("t4_valid", m_valid, 1);
    tick();
    chk("t4_in_resp", m_valid, 0);
    reset = 1'b0;
    #1;
    chk("t4_rst_valid", m_valid, 0);
    chk("t4_rst_addr", m_addr, 0);
    chk("t4_rst_done", if_done, 0);
    chk("t4_rst_if_rdata", if_rdata, 0);
    chk("t4_rst_ls_rdata", ls_rdata, 0);
    if_req = 1'b0;
    repeat (2) tick();
    chk("t4_no_done", if_done, 0);
    reset    = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h400;
    m_rvalid = 1'b1;
    m_rdata  = 32'h13;
    n = 0;
    do begin
      tick();
      n++;
    end while (!if_done && n < 20);
    chk("t4_latency", n, 3);
    chk("t4_rdata", if_rdata, 32'h13);
    if_req   = 1'b0;
    m_rvalid = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // load that never gets rvalid is aborted
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h500;
    tick();
    chk("t5_valid", m_valid, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ls_done && n < 40);
    chk("t5_abort_latency", n, TMO);
    chk("t5_rdata", ls_rdata, 32'hDEAD_BEEF);
    chk("t5_bus_err", bus_err, 1);
    ls_req = 1'b0;
    repeat (3) tick();
    chk("t5_bus_err_sticky", bus_err, 1);
`else
    chk("t5_bus_err_tied", bus_err, 0);
`endif

    // randomized traffic against a transaction-level model
    out_valid    = 1'b0;
    out_ls       = 1'b0;
    out_we       = 1'b0;
    data_ok      = 1'b0;
    resp_wait    = 1'b0;
    acc_prev     = 1'b0;
    m_valid_prev = 1'b0;
    if_prev      = 1'b0;
    ls_prev      = 1'b0;
    wait_cnt     = 0;
    rv_wait      = 0;
    run          = 0;
    exp_data     = '0;
    saved        = '0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      tick();
      chk("r_stall", stall, (if_req & ~if_done) | (ls_req & ~ls_done));
      if (acc_prev && !out_we) resp_wait = 1'b1;
      acc_prev = 1'b0;
      if (if_done || ls_done) begin
        chk("r_done_owner", {if_done, ls_done},
            (out_valid && data_ok) ? (out_ls ? 2'b01 : 2'b10) : 2'b00);
        if (if_done && !out_we) chk("r_if_rdata", if_rdata, exp_data);
        if (ls_done && !out_we) chk("r_ls_rdata", ls_rdata, exp_data);
        if (if_done) if_req = 1'b0;
        if (ls_done) ls_req = 1'b0;
        out_valid = 1'b0;
        data_ok   = 1'b0;
      end
      if (m_valid && !m_valid_prev) begin
        is_ls = m_addr[31];
        want  = is_ls ? {ls_we, ls_addr, ls_wdata, ls_be}
                      : {1'b0, if_addr, 32'h0, 4'hF};
        saved = {m_we, m_addr, m_wdata, m_be};
        chk("r_fields", saved, want);
        chk("r_one_outstanding", out_valid, 0);
        if (is_ls) begin
          if (if_prev) begin
            run++;
            chk("r_starve_bound", run <= LIMIT, 1);
          end
        end else begin
          if (ls_prev) chk("r_ls_priority", run == LIMIT, 1);
          run = 0;
        end
        out_valid = 1'b1;
        out_ls    = is_ls;
        out_we    = m_we;
        data_ok   = 1'b0;
      end else if (m_valid) begin
        chk("r_stable", {m_we, m_addr, m_wdata, m_be}, saved);
      end
      if (m_valid) begin
        wait_cnt++;
        m_ready = ($urandom_range(0, 2) != 0) || (wait_cnt >= 3);
        if (m_ready) begin
          acc_prev = 1'b1;
          wait_cnt = 0;
          if (m_we) data_ok = 1'b1;
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      m_rdata = $urandom;
      if (resp_wait) begin
        rv_wait++;
        m_rvalid = ($urandom_range(0, 1) != 0) || (rv_wait >= 3);
        if (m_rvalid) begin
          exp_data  = m_rdata;
          data_ok   = 1'b1;
          resp_wait = 1'b0;
          rv_wait   = 0;
        end
      end else begin
        m_rvalid = ($urandom_range(0, 3) == 0);
      end
      if (cyc < 3000) begin
        if (!if_req && !if_done && $urandom_range(0, 3) == 0) begin
          if_req  = 1'b1;
          if_addr = $urandom & 32'h7FFF_FFFC;
        end
        if (!ls_req && !ls_done && $urandom_range(0, 1) == 0) begin
          ls_req   = 1'b1;
          ls_we    = 1'($urandom_range(0, 1));
          ls_addr  = $urandom | 32'h8000_0000;
          ls_wdata = $urandom;
          ls_be    = 4'($urandom_range(0, 15));
        end
      end else if (!out_valid && !if_req && !ls_req) begin
        break;
      end
      if_prev      = if_req;
      ls_prev      = ls_req;
      m_valid_prev = m_valid;
    end
    chk("r_drained", {out_valid, if_req, ls_req}, 3'b000);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("r_bus_err_sticky", bus_err, 1);
`else
    chk("r_bus_err_tied", bus_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
